// File: rtl/sprite_line_scheduler_if.sv
// Bus bundle between the sprite line scheduler (master) and its line controller,
// attribute RAM and slot table (slave side).
interface sprite_line_scheduler_if;
  logic        line_start;
  logic [10:0] next_row;
  logic        attr_rd;
  logic [5:0]  attr_addr;
  logic [31:0] attr_data;
  logic        slot_wr;
  logic [2:0]  slot_idx;
  logic [11:0] slot_x;
  logic [5:0]  slot_pat;
  logic [1:0]  slot_pal;
  logic [3:0]  slot_row;
  logic [3:0]  slot_count;
  logic        overflow;
  logic        busy;
  logic        done;

  modport master (
    input  line_start, next_row, attr_data,
    output attr_rd, attr_addr, slot_wr, slot_idx, slot_x, slot_pat, slot_pal,
           slot_row, slot_count, overflow, busy, done
  );

  modport slave (
    output line_start, next_row, attr_data,
    input  attr_rd, attr_addr, slot_wr, slot_idx, slot_x, slot_pat, slot_pal,
           slot_row, slot_count, overflow, busy, done
  );
endinterface

// File: rtl/sprite_line_scheduler.sv
// Scans the sprite attribute table once per display line and writes up to
// MAX_PER_LINE sprites that cover the next row into the slot table.
//
// state | meaning
// IDLE  | waiting for line_start, results of last line held
// SCAN  | issuing attribute reads 0..N_SPRITES-1, evaluating previous read
// DRAIN | no read issued, evaluating the last returned entry
// DONE  | one-cycle done pulse, results final
module sprite_line_scheduler #(
  parameter int N_SPRITES    = 64,
  parameter int MAX_PER_LINE = 8,
  parameter int SPRITE_H     = 16
) (
  input logic                       clock,
  input logic                       reset,
  sprite_line_scheduler_if.master   bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam logic [5:0] LAST_IDX = 6'(N_SPRITES - 1);

  state_t      state_q;
  logic [10:0] row_q;
  logic [5:0]  idx_q;
  logic [3:0]  cnt_q;
  logic        ovf_q;
  logic        rd_q;
  logic        eval_q;
  logic        busy_q;
  logic        done_q;

  logic [11:0] diff_d;
  logic        hit_d;
  logic        room_d;
  logic        slot_wr_d;
  logic        ovf_hit_d;

  // eval_q marks that attr_data this cycle belongs to the current scan
  assign diff_d    = {1'b0, row_q} - {1'b0, bus.attr_data[10:0]};
  assign hit_d     = eval_q && bus.attr_data[31] && !diff_d[11] &&
                     (diff_d < 12'(SPRITE_H));
  assign room_d    = cnt_q < 4'(MAX_PER_LINE);
  assign slot_wr_d = hit_d && room_d && !bus.line_start;
  assign ovf_hit_d = hit_d && !room_d && !bus.line_start;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      rd_q    <= 1'b0;
      eval_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (bus.line_start) begin
      state_q <= SCAN;
      row_q   <= bus.next_row;
      idx_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      rd_q    <= 1'b1;
      eval_q  <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: state_q <= IDLE;
        SCAN: begin
          idx_q  <= idx_q + 6'd1;
          eval_q <= 1'b1;
          if (slot_wr_d) cnt_q <= cnt_q + 4'd1;
          if (ovf_hit_d) begin
            ovf_q   <= 1'b1;
            state_q <= DONE;
            rd_q    <= 1'b0;
            eval_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (idx_q == LAST_IDX) begin
            state_q <= DRAIN;
            rd_q    <= 1'b0;
          end
        end
        DRAIN: begin
          eval_q  <= 1'b0;
          if (slot_wr_d) cnt_q <= cnt_q + 4'd1;
          if (ovf_hit_d) ovf_q <= 1'b1;
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.attr_rd    = rd_q;
  assign bus.attr_addr  = rd_q ? idx_q : '0;
  assign bus.slot_wr    = slot_wr_d;
  assign bus.slot_idx   = slot_wr_d ? cnt_q[2:0] : '0;
  assign bus.slot_x     = slot_wr_d ? bus.attr_data[24:13] : '0;
  assign bus.slot_pat   = slot_wr_d ? bus.attr_data[30:25] : '0;
  assign bus.slot_pal   = slot_wr_d ? bus.attr_data[12:11] : '0;
  assign bus.slot_row   = slot_wr_d ? diff_d[3:0] : '0;
  assign bus.slot_count = cnt_q;
  assign bus.overflow   = ovf_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Randomised scoreboard bench for sprite_line_scheduler: a line-level model
// predicts slot writes and the done event, a negedge monitor checks them.
module tb_sprite_line_scheduler;
  localparam int N    = 64;
  localparam int MAXS = 8;
  localparam int H    = 16;

  logic clock = 1'b0;
  logic reset;
  sprite_line_scheduler_if bus();

  sprite_line_scheduler #(.N_SPRITES(N), .MAX_PER_LINE(MAXS), .SPRITE_H(H)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {int idx; int x; int pat; int pal; int row;} slot_t;
  typedef struct {int cyc; int cnt; int ovf; int reads;} done_t;

  slot_t       exp_slot_q[$];
  done_t       exp_done_q[$];
  logic [31:0] mem [N];
  int cyc = 0, ncmp = 0, nfail = 0, rd_seen = 0;
  int last_issue = 0, last_done_cyc = 0, last_cnt = 0, last_ovf = 0;
  slot_t es;
  done_t ed;

  // Attribute RAM: one-cycle read latency, junk on the bus when not read.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (bus.attr_rd) bus.attr_data <= mem[bus.attr_addr];
    else             bus.attr_data <= $urandom();
  end

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      if (bus.attr_rd && !bus.line_start) begin
        chk("attr_addr", int'(bus.attr_addr), rd_seen);
        chk("busy while reading", int'(bus.busy), 1);
        rd_seen++;
      end
      if (bus.slot_wr) begin
        if (exp_slot_q.size() == 0) chk("unexpected slot_wr", 1, 0);
        else begin
          es = exp_slot_q.pop_front();
          chk("slot_idx", int'(bus.slot_idx), es.idx);
          chk("slot_x",   int'(bus.slot_x),   es.x);
          chk("slot_pat", int'(bus.slot_pat), es.pat);
          chk("slot_pal", int'(bus.slot_pal), es.pal);
          chk("slot_row", int'(bus.slot_row), es.row);
        end
      end else begin
        chk("slot fields idle", int'({bus.slot_idx, bus.slot_x, bus.slot_pat,
                                      bus.slot_pal, bus.slot_row}), 0);
      end
      if (bus.done) begin
        if (exp_done_q.size() == 0) chk("unexpected done", 1, 0);
        else begin
          ed = exp_done_q.pop_front();
          chk("done cycle", cyc, ed.cyc);
          chk("slot_count at done", int'(bus.slot_count), ed.cnt);
          chk("overflow at done", int'(bus.overflow), ed.ovf);
          chk("reads issued", rd_seen, ed.reads);
          chk("busy at done", int'(bus.busy), 0);
        end
      end
    end
  end

  // Line-level reference: walk the table, collect hitting entries in order.
  task automatic model(input int row, input int t);
    int hits = 0;
    done_t d;
    d.cyc = t + N + 2; d.cnt = 0; d.ovf = 0; d.reads = N;
    for (int i = 0; i < N; i++) begin
      logic [31:0] w;
      int y;
      w = mem[i];
      y = int'(w[10:0]);
      if (w[31] && row >= y && row - y < H) begin
        if (hits == MAXS) begin
          d.ovf = 1; d.cyc = t + i + 3; d.reads = (i + 2 > N) ? N : i + 2;
          break;
        end
        exp_slot_q.push_back('{hits, int'(w[24:13]), int'(w[30:25]), int'(w[12:11]), row - y});
        hits++;
      end
    end
    d.cnt = hits;
    exp_done_q.push_back(d);
    last_done_cyc = d.cyc; last_cnt = d.cnt; last_ovf = d.ovf;
  endtask

  task automatic issue(input int row);
    @(posedge clock); #1;
    bus.line_start = 1'b1;
    bus.next_row   = 11'(row);
    exp_slot_q.delete(); exp_done_q.delete();
    rd_seen    = 0;
    last_issue = cyc;
    model(row, cyc);
    @(posedge clock); #1;
    bus.line_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (exp_done_q.size() != 0 && k < 300) begin
      @(negedge clock); k++;
    end
    if (exp_done_q.size() != 0) begin
      chk({tag, " done timeout"}, 0, 1);
      exp_done_q.delete(); exp_slot_q.delete();
    end else begin
      repeat (3) @(negedge clock);
      chk({tag, " slot_count held"}, int'(bus.slot_count), last_cnt);
      chk({tag, " overflow held"}, int'(bus.overflow), last_ovf);
      chk({tag, " missing slot_wr"}, exp_slot_q.size(), 0);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin @(posedge clock); #1; end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < N; i++) mem[i] = 32'h0000_0000;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int row, dens, lim, dl;
    logic [31:0] w;
    reset = 1'b0;
    bus.line_start = 1'b1;
    bus.next_row = 11'd5;
    clear_mem();
    repeat (3) @(negedge clock);
    chk("reset attr_rd", int'(bus.attr_rd), 0);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset done", int'(bus.done), 0);
    chk("reset slot_wr", int'(bus.slot_wr), 0);
    chk("reset slot_count", int'(bus.slot_count), 0);
    chk("reset overflow", int'(bus.overflow), 0);
    @(posedge clock); #1;
    bus.line_start = 1'b0;
    reset = 1'b1;
    repeat (5) @(negedge clock);
    chk("line_start in reset ignored", int'(bus.busy), 0);

    // All entries disabled.
    run_directed(300);
    // Single sprite at y=100, rows inside and just outside its span.
    mem[5] = {1'b1, 6'd3, 12'd200, 2'd2, 11'd100};
    run_directed(107);
    run_directed(115);
    run_directed(116);
    run_directed(99);
    // Ten sprites on one row: eight slots then overflow.
    clear_mem();
    for (int i = 0; i < 10; i++) mem[i] = {1'b1, 6'(i), 12'(i * 10), 2'(i), 11'd500};
    run_directed(500);
    // Restart mid-scan.
    clear_mem();
    for (int i = 0; i < 4; i++) mem[i] = {1'b1, 6'(i + 7), 12'(i + 40), 2'(i), 11'(590 + i)};
    issue(600);
    wait_until(last_issue + 19);
    issue(600);
    wait_done("restart");
    // Asynchronous reset mid-scan; no done may follow.
    for (int i = 40; i < 44; i++) mem[i] = {1'b1, 6'd1, 12'd9, 2'd1, 11'd595};
    issue(600);
    wait_until(last_issue + 29);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("async reset attr_rd", int'(bus.attr_rd), 0);
    chk("async reset busy", int'(bus.busy), 0);
    chk("async reset slot_wr", int'(bus.slot_wr), 0);
    chk("async reset slot_count", int'(bus.slot_count), 0);
    exp_slot_q.delete(); exp_done_q.delete();
    bus.line_start = 1'b1;
    @(posedge clock); #1;
    bus.line_start = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (80) @(negedge clock);
    chk("idle after reset release", int'(bus.busy), 0);

    for (int it = 0; it < 30; it++) begin
      row  = int'($urandom_range(0, 2047));
      dens = int'($urandom_range(5, 60));
      for (int i = 0; i < N; i++) begin
        w = $urandom();
        w[31] = ($urandom_range(0, 99) < dens);
        w[10:0] = 11'(row + int'($urandom_range(0, 40)) - 24);
        mem[i] = w;
      end
      issue(row);
      if ($urandom_range(0, 3) == 0) begin
        lim = last_done_cyc - last_issue - 1;
        dl  = int'($urandom_range(2, lim));
        wait_until(last_issue + dl - 1);
        issue(int'($urandom_range(0, 2047)));
      end
      wait_done("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  task automatic run_directed(input int row);
    issue(row);
    wait_done("directed");
  endtask

endmodule
